// File: rtl/seq_pattern_tx.sv
// Purpose: serial pattern transmitter; shifts a captured WIDTH-bit word out MSB-first, repeated with GAP filler bits.
// Latency: first bit is registered on the edge that accepts start; done pulses one enabled edge after the final bit.
// Backpressure: enable=0 freezes all state and x; x_valid/frame_done/done stay low until the next enabled edge.
// Optional build macro SEQ_PATTERN_TX_LFSR_GAP_EN: gap filler bits come from an 8-bit LFSR instead of zeros.
module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  // Frame-repeat count; "repeat" itself is a reserved word in SystemVerilog.
  input  logic [CNT_W-1:0] repeat_n,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             frame_done,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = 4;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_PEN  = BW'(WIDTH - 2);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             done_q, done_d;
  logic             fill_bit;

  // Next-state and registered-output logic; pulses default low, everything else holds.
  always_comb begin
    state_d      = state_q;
    pat_d        = pat_q;
    sh_d         = sh_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    frames_d     = frames_q;
    x_d          = x_q;
    x_valid_d    = 1'b0;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        x_d    = 1'b0;
        busy_d = 1'b0;
        if (enable && start) begin
          pat_d     = pattern;
          sh_d      = pattern;
          bit_cnt_d = '0;
          frames_d  = (repeat_n == '0) ? CNT_W'(1) : repeat_n;
          x_d       = pattern[WIDTH-1];
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (enable) begin
          x_valid_d = 1'b1;
          if (bit_cnt_q != BIT_LAST) begin
            // Next bit of the current frame; the shift register keeps the presented bit at its MSB.
            sh_d      = sh_q << 1;
            x_d       = sh_q[WIDTH-2];
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_PEN) begin
              frame_done_d = 1'b1;
              frames_d     = frames_q - 1'b1;
            end
          end else if (frames_q != '0) begin
            if (GAP > 0) begin
              state_d   = S_GAP;
              gap_cnt_d = '0;
              x_d       = fill_bit;
            end else begin
              sh_d      = pat_q;
              x_d       = pat_q[WIDTH-1];
              bit_cnt_d = '0;
            end
          end else begin
            // Final bit already presented: drop the line and signal completion.
            x_valid_d = 1'b0;
            x_d       = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            sh_d      = '0;
            bit_cnt_d = '0;
            state_d   = S_IDLE;
          end
        end
      end

      S_GAP: begin
        if (enable) begin
          x_valid_d = 1'b1;
          if (gap_cnt_q != GAP_LAST) begin
            gap_cnt_d = gap_cnt_q + 1'b1;
            x_d       = fill_bit;
          end else begin
            sh_d      = pat_q;
            x_d       = pat_q[WIDTH-1];
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            state_d   = S_SHIFT;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pat_q        <= '0;
      sh_q         <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      frames_q     <= '0;
      x_q          <= 1'b0;
      x_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      sh_q         <= sh_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      frames_q     <= frames_d;
      x_q          <= x_d;
      x_valid_q    <= x_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      done_q       <= done_d;
    end
  end

`ifdef SEQ_PATTERN_TX_LFSR_GAP_EN
  logic [7:0] lfsr_q, lfsr_d;

  assign fill_bit = lfsr_q[7];

  // Step the LFSR once per filler bit actually presented; start does not reseed it.
  always_comb begin
    lfsr_d = lfsr_q;
    if ((state_d == S_GAP) && x_valid_d) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // LFSR register, seeded on reset only.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign fill_bit = 1'b0;
`endif

  assign x          = x_q;
  assign x_valid    = x_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign done       = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: table vectors, hand-written stall/abort sequences, randomized stream model.
module tb_seq_pattern_tx;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int GAP   = 2;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             frame_done;
  logic             done;

  int tests = 0;
  int fails = 0;

  seq_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP(GAP)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .start      (start),
    .pattern    (pattern),
    .repeat_n   (repeat_n),
    .x          (x),
    .x_valid    (x_valid),
    .busy       (busy),
    .frame_done (frame_done),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pat;
    logic [3:0]  rpt;
    logic [63:0] bits;
    int          len;
    int          fds;
  } vec_t;

  vec_t vecs[4];

  // Reference stream for the randomized phase.
  logic q_x[$];
  logic q_fd[$];

`ifdef SEQ_PATTERN_TX_LFSR_GAP_EN
  logic [7:0] m_lfsr;
  task automatic next_fill(output logic b);
    b = m_lfsr[7];
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask
`else
  task automatic next_fill(output logic b);
    b = 1'b0;
  endtask
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    start  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
`ifdef SEQ_PATTERN_TX_LFSR_GAP_EN
    m_lfsr = 8'hA5;
`endif
  endtask

  int         busy_cnt;
  int         fd_cnt;
  int         done_cnt;
  int         done_at;
  int         idx;
  int         nf;
  logic       en_used;
  logic       last_x;
  logic       finished;
  logic       fb;
  logic [7:0] pb;
  logic [7:0] rpat;
  logic [3:0] rrpt;
  logic [4:0] exp_v;

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    start    = 1'b0;
    pattern  = '0;
    repeat_n = '0;

    vecs[0] = '{pat: 8'b10110011, rpt: 4'd1, bits: 64'b10110011, len: 8, fds: 1};
`ifdef SEQ_PATTERN_TX_LFSR_GAP_EN
    vecs[1] = '{pat: 8'hF0, rpt: 4'd3, bits: 64'b1111000010111100001011110000, len: 28, fds: 3};
    vecs[2] = '{pat: 8'h3C, rpt: 4'd2, bits: 64'b001111001000111100, len: 18, fds: 2};
`else
    vecs[1] = '{pat: 8'hF0, rpt: 4'd3, bits: 64'b1111000000111100000011110000, len: 28, fds: 3};
    vecs[2] = '{pat: 8'h3C, rpt: 4'd2, bits: 64'b001111000000111100, len: 18, fds: 2};
`endif
    vecs[3] = '{pat: 8'h81, rpt: 4'd0, bits: 64'b10000001, len: 8, fds: 1};

    // Reset state, and idle stays quiet with start=0.
    do_reset();
    check("reset outputs", {x, x_valid, busy, frame_done, done}, 5'b0);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("idle quiet %0d", i), {x, x_valid, busy, frame_done, done}, 5'b0);
    end
    // start with enable low in idle is neither accepted nor remembered.
    enable  = 1'b0;
    start   = 1'b1;
    pattern = 8'hFF;
    tick();
    check("start ignored en=0", {x_valid, busy}, 2'b00);
    start  = 1'b0;
    enable = 1'b1;
    tick();
    check("start not latched", {x_valid, busy}, 2'b00);

    // Table vectors, enable held high.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      pattern  = vecs[v].pat;
      repeat_n = vecs[v].rpt;
      enable   = 1'b1;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      pattern  = ~vecs[v].pat;
      repeat_n = 4'd7;
      busy_cnt = 0;
      fd_cnt   = 0;
      done_cnt = 0;
      done_at  = -1;
      for (int e = 1; e <= vecs[v].len + 3; e++) begin
        if (busy) busy_cnt++;
        if (frame_done) fd_cnt++;
        if (done) begin
          done_cnt++;
          if (done_at < 0) done_at = e;
        end
        if (e <= vecs[v].len) begin
          check($sformatf("vec%0d bit%0d", v, e), {x_valid, x}, {1'b1, vecs[v].bits[vecs[v].len - e]});
        end else begin
          check($sformatf("vec%0d tail%0d", v, e), x_valid, 1'b0);
        end
        tick();
      end
      check($sformatf("vec%0d busy cycles", v), busy_cnt, vecs[v].len);
      check($sformatf("vec%0d frame_done count", v), fd_cnt, vecs[v].fds);
      check($sformatf("vec%0d done edge", v), done_at, vecs[v].len + 1);
      check($sformatf("vec%0d done count", v), done_cnt, 1);
    end

    // Stall: enable low for three edges after the third bit.
    do_reset();
    pb       = 8'b10110011;
    pattern  = pb;
    repeat_n = 4'd1;
    enable   = 1'b1;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int e = 1; e <= 13; e++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (e <= 3) begin
        check($sformatf("stall bit%0d", e), {x_valid, x}, {1'b1, pb[8 - e]});
      end else if (e <= 6) begin
        check($sformatf("stall hold%0d", e), {x_valid, x, frame_done}, {1'b0, pb[5], 1'b0});
      end else if (e <= 11) begin
        check($sformatf("stall bit%0d", e - 3), {x_valid, x}, {1'b1, pb[11 - e]});
      end else if (e == 12) begin
        check("stall done", {done, busy, x_valid}, 3'b100);
      end
      if (e == 11) check("stall frame_done", frame_done, 1'b1);
      enable = !(e >= 3 && e <= 5);
      tick();
    end
    check("stall busy cycles", busy_cnt, 11);
    check("stall done count", done_cnt, 1);

    // Start during a frame is ignored; reset mid-frame aborts with no done.
    do_reset();
    pb       = 8'hAA;
    pattern  = pb;
    repeat_n = 4'd1;
    enable   = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      check($sformatf("abort bit%0d", e), {x_valid, x}, {1'b1, pb[8 - e]});
      if (e == 2) begin
        start    = 1'b1;
        pattern  = 8'h55;
        repeat_n = 4'd3;
      end else begin
        start = 1'b0;
      end
      if (e == 5) reset = 1'b1;
      tick();
    end
    check("abort outputs", {x, x_valid, busy, frame_done, done}, 5'b0);
    reset    = 1'b0;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    check("abort no done", done_cnt, 0);
    check("abort stays idle", busy_cnt, 0);

    // Randomized transactions against a stream model.
    do_reset();
    for (int t = 0; t < 40; t++) begin
      rpat = 8'($urandom);
      rrpt = 4'($urandom_range(0, 4));
      nf   = (rrpt == 0) ? 1 : int'(rrpt);
      q_x.delete();
      q_fd.delete();
      for (int f = 0; f < nf; f++) begin
        for (int i = WIDTH - 1; i >= 0; i--) begin
          q_x.push_back(rpat[i]);
          q_fd.push_back(i == 0);
        end
        if (f < nf - 1) begin
          for (int g = 0; g < GAP; g++) begin
            next_fill(fb);
            q_x.push_back(fb);
            q_fd.push_back(1'b0);
          end
        end
      end
      pattern  = rpat;
      repeat_n = rrpt;
      enable   = 1'b1;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      en_used  = 1'b1;
      idx      = 0;
      last_x   = 1'b0;
      finished = 1'b0;
      for (int c = 0; c < 400 && !finished; c++) begin
        if (!en_used) begin
          exp_v = {last_x, 1'b0, 1'b1, 1'b0, 1'b0};
        end else if (idx < q_x.size()) begin
          exp_v  = {q_x[idx], 1'b1, 1'b1, q_fd[idx], 1'b0};
          last_x = q_x[idx];
          idx++;
        end else begin
          exp_v    = 5'b00001;
          finished = 1'b1;
        end
        check($sformatf("rnd t%0d c%0d {x,xv,busy,fd,done}", t, c),
              {x, x_valid, busy, frame_done, done}, exp_v);
        if (!finished) begin
          en_used  = ($urandom_range(0, 3) != 0);
          enable   = en_used;
          start    = ($urandom_range(0, 5) == 0);
          pattern  = 8'($urandom);
          repeat_n = 4'($urandom);
          tick();
        end
      end
      if (!finished) check($sformatf("rnd t%0d timeout", t), 0, 1);
      start  = 1'b0;
      enable = 1'b1;
      tick();
      check($sformatf("rnd t%0d idle after done", t), {x, x_valid, busy, frame_done, done}, 5'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter: the stimulus-side counterpart of the sequence detector. It loads a WIDTH-bit pattern and shifts it out MSB-first on a single bit line `x`, one bit per enabled clock. The pattern repeats a programmable number of times, with GAP filler bits between frames. It drives the detector's serial input for on-chip self-test and for bench stimulus.

Parameters:
WIDTH, 8, pattern length in bits (2..32)
CNT_W, 4, width of the frame-repeat count
GAP, 2, filler bits between consecutive frames (0..15); 0 means back-to-back frames

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  advance enable; low freezes all state
start  in  1  request transmission; sampled only in IDLE with enable=1
pattern  in  WIDTH  pattern word, captured on accepted start
repeat  in  CNT_W  number of frames; 0 is treated as 1
x  out  1  serial data bit, registered
x_valid  out  1  x carries a pattern or gap bit this cycle
busy  out  1  transmission in progress
frame_done  out  1  one-cycle pulse coincident with the last bit of each frame
done  out  1  one-cycle pulse the cycle after the final bit

Behaviour:
- Reset (priority over everything):
  - state=IDLE; x, x_valid, busy, frame_done, done all 0.
  - Shift register, bit counter, gap counter and frame counter cleared.
  - A reset mid-transmission abandons the frame immediately; no done pulse.
- All outputs are registered. States are IDLE, SHIFT, GAP.
- IDLE:
  - x=0, x_valid=0, busy=0.
  - start=1 and enable=1 at edge k: capture pattern and repeat; frames_left = max(repeat,1).
  - At the same edge k: x=pattern[WIDTH-1], x_valid=1, busy=1; go to SHIFT. Start-to-first-bit latency is 1 edge.
- SHIFT, at each enabled edge:
  - Present the next bit, MSB to LSB.
  - Bit counter counts 0..WIDTH-1.
  - frame_done=1 registered together with bit WIDTH-1; frames_left decrements at that edge.
- After the last bit of a frame:
  - If frames remain and GAP>0: go to GAP.
  - If frames remain and GAP=0: reload the captured pattern and present its MSB on the next edge.
  - If no frames remain: at the next edge x=0, x_valid=0, busy=0, done=1 for one cycle, state=IDLE.
- GAP:
  - GAP enabled edges each present a filler bit (x=0 by default), x_valid=1.
  - Then reload the captured pattern; its MSB is presented at the following edge.
- Frame timing: frame n MSB appears (WIDTH+GAP)*n enabled edges after the first MSB.
- Total busy (all enable=1) = frames*WIDTH + (frames-1)*GAP cycles.
- enable=0 during SHIFT or GAP:
  - State, counters and x are held.
  - x_valid=0, frame_done=0, done=0.
  - Any pending pulse is issued on the edge where the bit is actually presented with enable=1.
- start while busy is ignored. The pattern and repeat inputs may change freely after capture.
- enable=0 in IDLE: start is ignored and not latched.
- done and a new accepted start may not coincide: start is only sampled in IDLE, i.e. from the edge after done onward.

Optional Feature:
SEQ_PATTERN_TX_LFSR_GAP_EN
- Defined: gap filler bits come from an 8-bit Fibonacci LFSR.
  - Seeded 8'hA5 at reset.
  - Output bit = lfsr[7]; next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Advances only on enabled GAP edges; not reseeded by start.
  - Purpose: stress the detector against false matches.
- Undefined: gap bits are 0 and no LFSR logic is present.
- Pattern bits and all timing are identical in both builds.

Test Plan:
- Reset: reset=1 for 2 cycles, then 0, with start=0 -> x, x_valid, busy, frame_done, done all 0 and stay 0.
- Single frame, WIDTH=8, GAP=2: pattern=8'b10110011, repeat=1, 1-cycle start -> x=1,0,1,1,0,0,1,1 on 8 consecutive edges with x_valid=1; frame_done with the 8th bit; done=1 on the 9th edge; busy high for exactly 8 cycles.
- Repeats: pattern=8'hF0, repeat=3 -> bit stream 11110000 00 11110000 00 11110000; 3 frame_done pulses, 1 done; busy high 28 cycles. With LFSR_GAP_EN the first gap is 1,0.
- Stall: repeat=1, enable=0 for 3 cycles after the 3rd bit -> x holds bit 3, x_valid=0 for 3 cycles, then bits 4..8 resume; busy high 11 cycles; done once.
- Ignored start and abort: pulse start with pattern 8'h55 during the 2nd bit of an 8'hAA frame -> stream continues as 8'hAA; assert reset at bit 5 -> next edge all outputs 0, no done pulse.
- Zero repeat: repeat=0, pattern=8'h81 -> exactly one frame 10000001, one frame_done, one done.
